// File: rtl/strum_envelope_sequencer.sv
// strum_envelope_sequencer
// Debounces the two strummer contacts, turns each accepted rising edge into
// one note event (fret selection latched as a 3-bit index) and runs an
// attack/sustain/release amplitude envelope paced by env_tick.
module strum_envelope_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ATTACK_STEP     = 8,
    parameter int RELEASE_STEP    = 1,
    parameter int SUSTAIN_TICKS   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] switches,
    input  logic       strummer_pos,
    input  logic       strummer_neg,
    input  logic       env_tick,
    output logic [2:0] note_sel,
    output logic [7:0] amplitude,
    output logic       note_valid,
    output logic       strum_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SUS_W = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    logic [1:0] raw;
    logic [1:0] rise;
    logic       strum_ev;

    assign raw = {strummer_neg, strummer_pos};

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic             sync1_q, sync2_q, db_q, db_prev_q;
        logic [CNT_W-1:0] cnt_q;

        // Synchronize the raw contact, then accept a new level only after it
        // has disagreed with the stable level for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= raw[g];
                sync2_q   <= sync1_q;
                db_prev_q <= db_q;
                if (sync2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q  <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign rise[g] = db_q & ~db_prev_q;
    end

    // Either contact rising is one strum; both at once still count once.
    assign strum_ev = |rise;

    state_t           state_q;
    logic [2:0]       note_q;
    logic [7:0]       amp_q;
    logic             valid_q;
    logic             pulse_q;
    logic [SUS_W-1:0] sus_cnt_q;

    logic [2:0] note_dec;
    logic [8:0] amp_up9, amp_dn9;
    logic [7:0] amp_up, amp_dn;

    // Fret decode: exactly one switch gives its index, anything else is 6.
    always_comb begin
        note_dec = 3'd6;
        if ($onehot(switches)) begin
            for (int k = 0; k < 7; k++) begin
                if (switches[k]) note_dec = 3'(k);
            end
        end
    end

    // Saturating envelope steps using a 9-bit intermediate (bit 8 flags
    // overflow on the way up and borrow on the way down).
    always_comb begin
        amp_up9 = {1'b0, amp_q} + 9'(ATTACK_STEP);
        amp_dn9 = {1'b0, amp_q} - 9'(RELEASE_STEP);
        amp_up  = amp_up9[8] ? 8'hFF : amp_up9[7:0];
        amp_dn  = amp_dn9[8] ? 8'h00 : amp_dn9[7:0];
    end

    // Envelope FSM; a strum retriggers from the current level and beats
    // env_tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            note_q    <= 3'd0;
            amp_q     <= 8'd0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            sus_cnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (strum_ev) begin
                note_q  <= note_dec;
                pulse_q <= 1'b1;
                valid_q <= 1'b1;
                state_q <= S_ATTACK;
            end else if (env_tick) begin
                case (state_q)
                    S_ATTACK: begin
                        amp_q <= amp_up;
                        if (amp_up == 8'hFF) begin
                            state_q   <= S_SUSTAIN;
                            sus_cnt_q <= '0;
                        end
                    end
                    S_SUSTAIN: begin
                        if (sus_cnt_q == SUS_W'(SUSTAIN_TICKS - 1)) begin
                            state_q   <= S_RELEASE;
                            sus_cnt_q <= '0;
                        end else begin
                            sus_cnt_q <= sus_cnt_q + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        amp_q <= amp_dn;
                        if (amp_dn == 8'h00) begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign note_sel    = note_q;
    assign amplitude   = amp_q;
    assign note_valid  = valid_q;
    assign strum_pulse = pulse_q;

endmodule

// File: tb/tb_strum_envelope_sequencer.sv
// Bench for strum_envelope_sequencer: directed scenarios plus a random
// stretch, every cycle compared against a behavioural envelope model.
module tb_strum_envelope_sequencer;

    localparam int DB = 4;
    localparam int AS = 64;
    localparam int RS = 85;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] switches = 7'd0;
    logic       strummer_pos = 1'b0;
    logic       strummer_neg = 1'b0;
    logic       env_tick = 1'b1;
    logic [2:0] note_sel;
    logic [7:0] amplitude;
    logic       note_valid;
    logic       strum_pulse;

    strum_envelope_sequencer #(
        .DEBOUNCE_CYCLES(DB), .ATTACK_STEP(AS),
        .RELEASE_STEP(RS), .SUSTAIN_TICKS(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches),
        .strummer_pos(strummer_pos), .strummer_neg(strummer_neg),
        .env_tick(env_tick), .note_sel(note_sel), .amplitude(amplitude),
        .note_valid(note_valid), .strum_pulse(strum_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: phase 0 silent, 1 rising, 2 holding, 3 falling.
    int m_phase, m_amp, m_ticks, m_note, m_pulse;
    int hist[2][$];
    int stable[2], stable_old[2], run[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_phase = 0; m_amp = 0; m_ticks = 0; m_note = 0; m_pulse = 0;
        for (int c = 0; c < 2; c++) begin
            hist[c] = '{0, 0};
            stable[c] = 0; stable_old[c] = 0; run[c] = 0;
        end
    endfunction

    function automatic int decode(input logic [6:0] sw);
        int n, idx;
        n = 0; idx = 6;
        for (int k = 0; k < 7; k++) if (sw[k]) begin n++; idx = k; end
        return (n == 1) ? idx : 6;
    endfunction

    function automatic void m_edge(input logic p, input logic n,
                                   input logic [6:0] sw, input logic tk);
        bit ev;
        int seen;
        ev = (stable[0] == 1 && stable_old[0] == 0) ||
             (stable[1] == 1 && stable_old[1] == 0);
        for (int c = 0; c < 2; c++) begin
            hist[c].push_front(c == 0 ? int'(p) : int'(n));
            seen = hist[c][2];
            void'(hist[c].pop_back());
            stable_old[c] = stable[c];
            if (seen != stable[c]) begin
                run[c]++;
                if (run[c] == DB) begin stable[c] = seen; run[c] = 0; end
            end else run[c] = 0;
        end
        m_pulse = 0;
        if (ev) begin
            m_note = decode(sw); m_pulse = 1; m_phase = 1;
        end else if (tk) begin
            if (m_phase == 1) begin
                m_amp = (m_amp + AS > 255) ? 255 : m_amp + AS;
                if (m_amp == 255) begin m_phase = 2; m_ticks = 0; end
            end else if (m_phase == 2) begin
                m_ticks++;
                if (m_ticks == ST) begin m_phase = 3; m_ticks = 0; end
            end else if (m_phase == 3) begin
                m_amp = (m_amp - RS < 0) ? 0 : m_amp - RS;
                if (m_amp == 0) m_phase = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_edge(strummer_pos, strummer_neg, switches, env_tick);
        #1;
        chk("model_note_sel", note_sel, m_note);
        chk("model_amplitude", amplitude, m_amp);
        chk("model_note_valid", note_valid, m_phase != 0);
        chk("model_strum_pulse", strum_pulse, m_pulse);
    endtask

    task automatic wait_pulse(output int n, input int maxc);
        n = 0;
        do begin step(); n++; end while (!strum_pulse && n < maxc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (note_valid && n < 60) begin step(); n++; end
        chk("idle_reached", note_valid, 1'b0);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, np;
        int exp_amp[10];
        exp_amp = '{64, 128, 192, 255, 255, 255, 255, 170, 85, 0};
        m_reset();

        // Reset state
        #1;
        chk("rst_note_sel", note_sel, 3'd0);
        chk("rst_amplitude", amplitude, 8'd0);
        chk("rst_note_valid", note_valid, 1'b0);
        chk("rst_strum_pulse", strum_pulse, 1'b0);
        settle(2);
        rst_n = 1'b1;
        settle(3);

        // Basic note
        switches = 7'b0000100; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        chk("basic_latency", n, 7);
        chk("basic_note", note_sel, 3'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("basic_amp_seq", amplitude, exp_amp[i]);
        end
        chk("basic_valid_fall", note_valid, 1'b0);
        strummer_neg = 1'b0;
        settle(10);

        // Bounce rejection
        np = 0;
        for (int i = 0; i < 20; i++) begin
            strummer_pos = ~strummer_pos;
            step(); np += strum_pulse;
            step(); np += strum_pulse;
        end
        chk("bounce_no_event", np, 0);
        strummer_pos = 1'b1;
        wait_pulse(n, 20);
        chk("bounce_latency", n, 7);
        np = 0;
        for (int i = 0; i < 10; i++) begin step(); np += strum_pulse; end
        chk("bounce_single", np, 0);
        strummer_pos = 1'b0;
        wait_idle();
        settle(8);

        // Invalid fret
        switches = 7'b0000000; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        chk("invalid_zero_note", note_sel, 3'd6);
        strummer_neg = 1'b0;
        settle(8);
        switches = 7'b0100010; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        chk("invalid_multi_latency", n, 7);
        chk("invalid_multi_note", note_sel, 3'd6);
        strummer_neg = 1'b0;
        wait_idle();
        settle(8);

        // Retrigger during release at amplitude 170
        switches = 7'b1000000; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        chk("retrig_first_note", note_sel, 3'd6);
        strummer_neg = 1'b0;
        settle(2);
        strummer_pos = 1'b1; switches = 7'b0000001;
        settle(6);
        chk("retrig_pre_amp", amplitude, 8'd170);
        chk("retrig_pre_note", note_sel, 3'd6);
        step();
        chk("retrig_pulse", strum_pulse, 1'b1);
        chk("retrig_note", note_sel, 3'd0);
        chk("retrig_amp_hold", amplitude, 8'd170);
        step();
        chk("retrig_amp_234", amplitude, 8'd234);
        step();
        chk("retrig_amp_255", amplitude, 8'd255);
        strummer_pos = 1'b0;
        wait_idle();
        settle(8);

        // Simultaneous edges, switches change afterwards
        switches = 7'b0001000; strummer_pos = 1'b1; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        chk("simul_latency", n, 7);
        switches = 7'b0000010;
        np = 0;
        for (int i = 0; i < 20; i++) begin step(); np += strum_pulse; end
        chk("simul_single", np, 0);
        chk("switch_hold_note", note_sel, 3'd3);
        strummer_pos = 1'b0; strummer_neg = 1'b0;
        wait_idle();
        settle(8);

        // Reset mid-sustain with strummer held
        switches = 7'b0010000; strummer_neg = 1'b1;
        wait_pulse(n, 20);
        settle(5);
        chk("pre_reset_amp", amplitude, 8'd255);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("midrst_note_sel", note_sel, 3'd0);
        chk("midrst_amplitude", amplitude, 8'd0);
        chk("midrst_note_valid", note_valid, 1'b0);
        chk("midrst_strum_pulse", strum_pulse, 1'b0);
        settle(2);
        rst_n = 1'b1;
        wait_pulse(n, 20);
        chk("post_reset_latency", n, 7);
        chk("post_reset_note", note_sel, 3'd4);
        strummer_neg = 1'b0;
        wait_idle();

        // Random stretch
        begin
            int hp, hn;
            hp = 0; hn = 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 9) == 0) switches = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 7) == 0) switches = 7'(1 << $urandom_range(0, 6));
                if (hp == 0) begin
                    strummer_pos = 1'($urandom_range(0, 1)); hp = $urandom_range(1, 14);
                end else hp--;
                if (hn == 0) begin
                    strummer_neg = 1'($urandom_range(0, 1)); hn = $urandom_range(1, 14);
                end else hn--;
                env_tick = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
